// File: rtl/lane_object_mux.sv
// lane_object_mux
//   Multi-lane, multi-variant sprite selector for the road scene. Each lane
//   carries NUM_TYPES object variants. A lane's variant change is requested
//   on its ready strobe and only takes effect at start of frame, so a sprite
//   never switches variant mid-frame. Every pixel, the lanes' active-variant
//   drawing requests are resolved by fixed lane priority. The winning colour
//   and its lane/type identity are registered out with one clock of latency.
//
// Ports
//   clk             system clock
//   resetN          synchronous reset, active high
//   start_of_frame  one-cycle pulse; commits every lane's pending selection
//   lane_ready      per-lane request strobe
//   lane_type_req   per-lane requested variant, lane i at [i*TYPE_W +: TYPE_W]
//   obj_dr          drawing request of lane i variant t at bit i*NUM_TYPES+t
//   obj_rgb         colour of lane i variant t at [(i*NUM_TYPES+t)*8 +: 8]
//   drawing_request registered: some lane draws this pixel
//   RGBOut          registered winning colour (0 when nothing draws)
//   lane_out        registered winning lane index (0 when nothing draws)
//   type_out        registered winning lane's active variant (0 when idle)
//   type_active     committed variant per lane (direct register output)
//   pending         per-lane flag: an uncommitted request is held

// ---------------------------------------------------------------------------
// Per-lane slice: request capture, frame-synchronous commit, and selection of
// the active variant's drawing request and colour.
// ---------------------------------------------------------------------------
module lane_object_mux_lane #(
    parameter int NUM_TYPES = 2,
    parameter int TYPE_W    = 3
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          start_of_frame,
    input  logic                          ready,
    input  logic [TYPE_W-1:0]             type_req,
    input  logic [NUM_TYPES-1:0]          dr,
    input  logic [NUM_TYPES-1:0][7:0]     rgb,
    output logic [TYPE_W-1:0]             type_active,
    output logic                          pending,
    output logic                          lane_dr,
    output logic [7:0]                    lane_rgb
);
    // One extra bit so NUM_TYPES == 2**TYPE_W still compares correctly.
    localparam logic [TYPE_W:0] TYPE_LIMIT = NUM_TYPES[TYPE_W:0];

    logic [TYPE_W-1:0] pend_type;
    logic              req_ok;

    assign req_ok = ({1'b0, type_req} < TYPE_LIMIT);

    // Commit uses the pending value held before this edge; a request arriving
    // on the same edge is written afterwards, so it re-arms pending and waits
    // for the next frame.
    always_ff @(posedge clk) begin
        if (resetN) begin
            type_active <= '0;
            pending     <= 1'b0;
            pend_type   <= '0;
        end else begin
            if (start_of_frame && pending) begin
                type_active <= pend_type;
                pending     <= 1'b0;
            end
            if (ready && req_ok) begin
                pend_type <= type_req;
                pending   <= 1'b1;
            end
        end
    end

    // Only the committed variant is visible; the others are ignored.
    always_comb begin
        lane_dr  = 1'b0;
        lane_rgb = 8'h00;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (type_active == TYPE_W'(t)) begin
                lane_dr  = dr[t];
                lane_rgb = rgb[t];
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top: lane array plus the fixed-priority pixel resolver.
// ---------------------------------------------------------------------------
module lane_object_mux #(
    parameter int NUM_LANES = 4,
    parameter int NUM_TYPES = 2,
    parameter int TYPE_W    = 3,
    parameter int LANE_W    = 4,
    parameter int LOW_FIRST = 1
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              start_of_frame,
    input  logic [NUM_LANES-1:0]              lane_ready,
    input  logic [NUM_LANES*TYPE_W-1:0]       lane_type_req,
    input  logic [NUM_LANES*NUM_TYPES-1:0]    obj_dr,
    input  logic [NUM_LANES*NUM_TYPES*8-1:0]  obj_rgb,
    output logic                              drawing_request,
    output logic [7:0]                        RGBOut,
    output logic [LANE_W-1:0]                 lane_out,
    output logic [TYPE_W-1:0]                 type_out,
    output logic [NUM_LANES*TYPE_W-1:0]       type_active,
    output logic [NUM_LANES-1:0]              pending
);
    typedef struct packed {
        logic              dr;
        logic [7:0]        rgb;
        logic [LANE_W-1:0] lane;
        logic [TYPE_W-1:0] typ;
    } pix_t;

    // Packed views share the flat port layout bit-for-bit.
    logic [NUM_LANES-1:0][TYPE_W-1:0]          req_a;
    logic [NUM_LANES-1:0][TYPE_W-1:0]          act_a;
    logic [NUM_LANES-1:0][NUM_TYPES-1:0]       dr_a;
    logic [NUM_LANES-1:0][NUM_TYPES-1:0][7:0]  rgb_a;
    logic [NUM_LANES-1:0]                      lane_dr;
    logic [NUM_LANES-1:0][7:0]                 lane_rgb;

    assign req_a       = lane_type_req;
    assign dr_a        = obj_dr;
    assign rgb_a       = obj_rgb;
    assign type_active = act_a;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_object_mux_lane #(
            .NUM_TYPES (NUM_TYPES),
            .TYPE_W    (TYPE_W)
        ) u_lane (
            .clk            (clk),
            .resetN         (resetN),
            .start_of_frame (start_of_frame),
            .ready          (lane_ready[g]),
            .type_req       (req_a[g]),
            .dr             (dr_a[g]),
            .rgb            (rgb_a[g]),
            .type_active    (act_a[g]),
            .pending        (pending[g]),
            .lane_dr        (lane_dr[g]),
            .lane_rgb       (lane_rgb[g])
        );
    end

    // Scan from the losing end toward the preferred end; the last hit found
    // is the winner. type_active here is the pre-commit value, matching what
    // the lanes present this cycle.
    pix_t win, pix_q;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LOW_FIRST != 0) begin
                if (lane_dr[NUM_LANES-1-i]) begin
                    win.dr   = 1'b1;
                    win.rgb  = lane_rgb[NUM_LANES-1-i];
                    win.lane = LANE_W'(NUM_LANES-1-i);
                    win.typ  = act_a[NUM_LANES-1-i];
                end
            end else begin
                if (lane_dr[i]) begin
                    win.dr   = 1'b1;
                    win.rgb  = lane_rgb[i];
                    win.lane = LANE_W'(i);
                    win.typ  = act_a[i];
                end
            end
        end
    end

    // No winner leaves win all-zero, which clears every pixel output.
    always_ff @(posedge clk) begin
        if (resetN) pix_q <= '0;
        else        pix_q <= win;
    end

    assign drawing_request = pix_q.dr;
    assign RGBOut          = pix_q.rgb;
    assign lane_out        = pix_q.lane;
    assign type_out        = pix_q.typ;
endmodule

// File: tb/tb_lane_object_mux.sv
module tb_lane_object_mux;
    localparam int NL = 4;
    localparam int NT = 2;
    localparam int TW = 3;
    localparam int LW = 4;

    typedef struct packed {
        logic          dr;
        logic [7:0]    rgb;
        logic [LW-1:0] lane;
        logic [TW-1:0] typ;
    } pix_t;

    logic               clk = 1'b0;
    logic               resetN;
    logic               start_of_frame;
    logic [NL-1:0]      lane_ready;
    logic [NL*TW-1:0]   lane_type_req;
    logic [NL*NT-1:0]   obj_dr;
    logic [NL*NT*8-1:0] obj_rgb;

    logic               lo_dr, hi_dr;
    logic [7:0]         lo_rgb, hi_rgb;
    logic [LW-1:0]      lo_lane, hi_lane;
    logic [TW-1:0]      lo_typ, hi_typ;
    logic [NL*TW-1:0]   lo_act, hi_act;
    logic [NL-1:0]      lo_pend, hi_pend;

    pix_t pix_lo, pix_hi;
    assign pix_lo = {lo_dr, lo_rgb, lo_lane, lo_typ};
    assign pix_hi = {hi_dr, hi_rgb, hi_lane, hi_typ};

    always #5 clk = ~clk;

    lane_object_mux #(.NUM_LANES(NL), .NUM_TYPES(NT), .TYPE_W(TW), .LANE_W(LW), .LOW_FIRST(1)) dut (
        .clk(clk), .resetN(resetN), .start_of_frame(start_of_frame),
        .lane_ready(lane_ready), .lane_type_req(lane_type_req),
        .obj_dr(obj_dr), .obj_rgb(obj_rgb),
        .drawing_request(lo_dr), .RGBOut(lo_rgb), .lane_out(lo_lane), .type_out(lo_typ),
        .type_active(lo_act), .pending(lo_pend));

    lane_object_mux #(.NUM_LANES(NL), .NUM_TYPES(NT), .TYPE_W(TW), .LANE_W(LW), .LOW_FIRST(0)) dut_hi (
        .clk(clk), .resetN(resetN), .start_of_frame(start_of_frame),
        .lane_ready(lane_ready), .lane_type_req(lane_type_req),
        .obj_dr(obj_dr), .obj_rgb(obj_rgb),
        .drawing_request(hi_dr), .RGBOut(hi_rgb), .lane_out(hi_lane), .type_out(hi_typ),
        .type_active(hi_act), .pending(hi_pend));

    int errors = 0;
    int checks = 0;

    // Reference state and expected-pixel scoreboards
    int   m_act [NL];
    int   m_pt  [NL];
    bit   m_pend[NL];
    pix_t q_lo[$];
    pix_t q_hi[$];

    function automatic pix_t exp_pix(bit low_first);
        pix_t p = '0;
        for (int k = 0; k < NL; k++) begin
            int l = low_first ? k : NL - 1 - k;
            int b = l * NT + m_act[l];
            if (obj_dr[b]) begin
                p.dr   = 1'b1;
                p.rgb  = obj_rgb[b*8 +: 8];
                p.lane = LW'(l);
                p.typ  = TW'(m_act[l]);
                break;
            end
        end
        return p;
    endfunction

    function automatic logic [NL*TW-1:0] m_act_vec();
        logic [NL*TW-1:0] v = '0;
        for (int l = 0; l < NL; l++) v[l*TW +: TW] = TW'(m_act[l]);
        return v;
    endfunction

    function automatic logic [NL-1:0] m_pend_vec();
        logic [NL-1:0] v = '0;
        for (int l = 0; l < NL; l++) v[l] = m_pend[l];
        return v;
    endfunction

    // Push expected pixels for the coming edge, advance the model, take the edge.
    task automatic tick();
        pix_t a, b;
        if (resetN) begin
            a = '0;
            b = '0;
        end else begin
            a = exp_pix(1'b1);
            b = exp_pix(1'b0);
        end
        q_lo.push_back(a);
        q_hi.push_back(b);
        for (int l = 0; l < NL; l++) begin
            if (resetN) begin
                m_act[l] = 0; m_pt[l] = 0; m_pend[l] = 0;
            end else begin
                int r = int'(lane_type_req[l*TW +: TW]);
                if (start_of_frame && m_pend[l]) begin
                    m_act[l]  = m_pt[l];
                    m_pend[l] = 0;
                end
                if (lane_ready[l] && r < NT) begin
                    m_pt[l]   = r;
                    m_pend[l] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int lane, int val);
        lane_type_req[lane*TW +: TW] = TW'(val);
    endtask

    task automatic idle_inputs();
        start_of_frame = 1'b0;
        lane_ready     = '0;
        lane_type_req  = '0;
    endtask

    task automatic test_reset();
        pix_t e;
        resetN = 1'b1;
        idle_inputs();
        obj_dr  = '1;
        obj_rgb = 64'h8877_6655_4433_2211;
        repeat (2) begin
            tick();
            e = q_lo.pop_front(); void'(q_hi.pop_front());
            checks++;
            if (pix_lo !== e) begin errors++; $display("FAIL reset_pix got=%h exp=%h", pix_lo, e); end
        end
        checks++;
        if (lo_act !== '0 || lo_pend !== 4'b0000) begin
            errors++; $display("FAIL reset_state act=%h pend=%b exp act=0 pend=0000", lo_act, lo_pend);
        end
        resetN = 1'b0;
        tick();
        e = q_lo.pop_front();
        checks++;
        if (pix_lo !== e || lo_dr !== 1'b1 || lo_lane !== 4'd0 || lo_typ !== 3'd0 || lo_rgb !== 8'h11) begin
            errors++; $display("FAIL release_pix got=%h exp=%h", pix_lo, e);
        end
        e = q_hi.pop_front();
        checks++;
        if (pix_hi !== e || hi_lane !== 4'd3 || hi_rgb !== 8'h77) begin
            errors++; $display("FAIL release_pix_hi got=%h exp=%h", pix_hi, e);
        end
    endtask

    task automatic test_deferred_commit();
        pix_t e;
        obj_dr  = '0;
        obj_rgb = '0;
        lane_ready = 4'b0100;
        set_req(2, 1);
        tick();
        idle_inputs();
        void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_pend !== 4'b0100 || lo_act[2*TW +: TW] !== 3'd0) begin
            errors++; $display("FAIL deferred_pending pend=%b act2=%0d exp pend=0100 act2=0", lo_pend, lo_act[2*TW +: TW]);
        end
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
        void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_pend !== 4'b0000 || lo_act[2*TW +: TW] !== 3'd1) begin
            errors++; $display("FAIL deferred_commit pend=%b act2=%0d exp pend=0000 act2=1", lo_pend, lo_act[2*TW +: TW]);
        end
        obj_dr = 8'b0010_0000;
        obj_rgb[5*8 +: 8] = 8'h3C;
        obj_rgb[4*8 +: 8] = 8'hEE;   // inactive variant of lane 2
        tick();
        e = q_lo.pop_front(); void'(q_hi.pop_front());
        checks++;
        if (pix_lo !== e || lo_dr !== 1'b1 || lo_rgb !== 8'h3C || lo_lane !== 4'd2 || lo_typ !== 3'd1) begin
            errors++; $display("FAIL deferred_pix got=%h exp=%h", pix_lo, e);
        end
        obj_dr = 8'b0001_0000;   // only the inactive variant requests
        tick();
        e = q_lo.pop_front(); void'(q_hi.pop_front());
        checks++;
        if (pix_lo !== e || lo_dr !== 1'b0 || lo_rgb !== 8'h00) begin
            errors++; $display("FAIL inactive_ignored got=%h exp=%h", pix_lo, e);
        end
    endtask

    task automatic test_priority();
        pix_t e;
        obj_rgb = '0;
        obj_dr  = 8'b0100_0100;
        obj_rgb[2*8 +: 8] = 8'hA0;
        obj_rgb[6*8 +: 8] = 8'h0F;
        tick();
        e = q_lo.pop_front();
        checks++;
        if (pix_lo !== e || lo_rgb !== 8'hA0 || lo_lane !== 4'd1) begin
            errors++; $display("FAIL prio_low got=%h exp=%h", pix_lo, e);
        end
        e = q_hi.pop_front();
        checks++;
        if (pix_hi !== e || hi_rgb !== 8'h0F || hi_lane !== 4'd3) begin
            errors++; $display("FAIL prio_high got=%h exp=%h", pix_hi, e);
        end
        obj_dr = '0;
    endtask

    task automatic test_simultaneous();
        lane_ready = 4'b0001;
        set_req(0, 1);
        tick();
        void'(q_lo.pop_front()); void'(q_hi.pop_front());
        set_req(0, 0);
        start_of_frame = 1'b1;
        tick();
        idle_inputs();
        void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_act[0 +: TW] !== 3'd1 || lo_pend[0] !== 1'b1) begin
            errors++; $display("FAIL simul_edge act0=%0d pend0=%b exp act0=1 pend0=1", lo_act[0 +: TW], lo_pend[0]);
        end
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
        void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_act[0 +: TW] !== 3'd0 || lo_pend[0] !== 1'b0) begin
            errors++; $display("FAIL simul_next act0=%0d pend0=%b exp act0=0 pend0=0", lo_act[0 +: TW], lo_pend[0]);
        end
    endtask

    task automatic test_invalid_last_wins();
        // Start with lane 1 on variant 1 so a final value of 0 is visible.
        lane_ready = 4'b0010; set_req(1, 1); start_of_frame = 1'b0;
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        idle_inputs(); start_of_frame = 1'b1;
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        start_of_frame = 1'b0;
        lane_ready = 4'b0010; set_req(1, 5);
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_pend !== 4'b0000) begin errors++; $display("FAIL invalid_req pend=%b exp=0000", lo_pend); end
        set_req(1, 1);
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        checks++;
        if (lo_pend !== 4'b0010) begin errors++; $display("FAIL valid_req pend=%b exp=0010", lo_pend); end
        set_req(1, 0);
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        idle_inputs(); start_of_frame = 1'b1;
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        start_of_frame = 1'b0;
        checks++;
        if (lo_act[1*TW +: TW] !== 3'd0 || lo_pend !== 4'b0000) begin
            errors++; $display("FAIL last_wins act1=%0d pend=%b exp act1=0 pend=0000", lo_act[1*TW +: TW], lo_pend);
        end
    endtask

    task automatic test_reset_mid();
        lane_ready = 4'b1111;
        for (int l = 0; l < NL; l++) set_req(l, 1);
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        idle_inputs();
        checks++;
        if (lo_pend !== 4'b1111) begin errors++; $display("FAIL mid_pending pend=%b exp=1111", lo_pend); end
        resetN = 1'b1;
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        resetN = 1'b0;
        start_of_frame = 1'b1;
        tick(); void'(q_lo.pop_front()); void'(q_hi.pop_front());
        start_of_frame = 1'b0;
        checks++;
        if (lo_act !== '0 || lo_pend !== 4'b0000) begin
            errors++; $display("FAIL mid_reset act=%h pend=%b exp act=0 pend=0000", lo_act, lo_pend);
        end
    endtask

    task automatic test_back_to_back();
        pix_t e;
        for (int n = 0; n < 60; n++) begin
            resetN         = ($urandom_range(0, 19) == 0);
            start_of_frame = ($urandom_range(0, 3) == 0);
            lane_ready     = NL'($urandom);
            lane_type_req  = (NL*TW)'($urandom);
            obj_dr         = (NL*NT)'($urandom);
            obj_rgb        = {$urandom, $urandom};
            tick();
            e = q_lo.pop_front();
            checks++;
            if (pix_lo !== e) begin errors++; $display("FAIL b2b_pix_lo n=%0d got=%h exp=%h", n, pix_lo, e); end
            e = q_hi.pop_front();
            checks++;
            if (pix_hi !== e) begin errors++; $display("FAIL b2b_pix_hi n=%0d got=%h exp=%h", n, pix_hi, e); end
            checks++;
            if (lo_act !== m_act_vec() || lo_pend !== m_pend_vec()) begin
                errors++; $display("FAIL b2b_state n=%0d act=%h pend=%b exp act=%h pend=%b",
                                   n, lo_act, lo_pend, m_act_vec(), m_pend_vec());
            end
        end
        resetN = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin m_act[l] = 0; m_pt[l] = 0; m_pend[l] = 0; end
        test_reset();
        test_deferred_commit();
        test_priority();
        test_simultaneous();
        test_invalid_last_wins();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
